// File: rtl/dcache_tag_ctrl_if.sv
// Requester-side bus of the dcache tag controller.
// Lookup (read) and update (write) ports share one SRAM.
interface dcache_tag_ctrl_if #(
  parameter int TAG_WIDTH      = 24,
  parameter int SET_ADDR_WIDTH = 4
);
  logic                      lk_req;
  logic [SET_ADDR_WIDTH-1:0] lk_addr;
  logic                      lk_gnt;
  logic                      lk_rvalid;
  logic [TAG_WIDTH-1:0]      lk_rdata;

  logic                      up_req;
  logic [SET_ADDR_WIDTH-1:0] up_addr;
  logic [TAG_WIDTH-1:0]      up_wdata;
  logic                      up_gnt;

  modport master (
    output lk_req, lk_addr,
    output up_req, up_addr, up_wdata,
    input  lk_gnt, lk_rvalid, lk_rdata,
    input  up_gnt
  );

  modport slave (
    input  lk_req, lk_addr,
    input  up_req, up_addr, up_wdata,
    output lk_gnt, lk_rvalid, lk_rdata,
    output up_gnt
  );
endinterface

// File: rtl/dcache_tag_ctrl.sv
// Tag SRAM sequencer: zeroing sweep, round-robin
// lookup/update arbitration, fixed 2-cycle reads.
module dcache_tag_ctrl #(
  parameter int TAG_WIDTH      = 24,
  parameter int SET_ADDR_WIDTH = 4,
  parameter int NUM_SETS       = 1 << SET_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_req,
  output logic                      init_done,
  dcache_tag_ctrl_if.slave          bus,
  output logic                      sram_csb0,
  output logic                      sram_web0,
  output logic [SET_ADDR_WIDTH-1:0] sram_addr0,
  output logic [TAG_WIDTH-1:0]      sram_din0,
  input  logic [TAG_WIDTH-1:0]      sram_dout0
);

  localparam logic [SET_ADDR_WIDTH-1:0] LAST =
    SET_ADDR_WIDTH'(NUM_SETS - 1);

  typedef enum logic {
    SWEEP,
    RUN
  } state_t;

  state_t                    state_q, state_d;
  logic [SET_ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                      rr_up_q, rr_up_d;
  logic                      init_d;
  logic                      csb_d, web_d;
  logic [SET_ADDR_WIDTH-1:0] addr_d;
  logic [TAG_WIDTH-1:0]      din_d;
  logic                      lk_gnt, up_gnt;
  logic [1:0]                rd_q;
  logic                      rvalid_q;
  logic [TAG_WIDTH-1:0]      rdata_q;

  assign bus.lk_gnt    = lk_gnt;
  assign bus.up_gnt    = up_gnt;
  assign bus.lk_rvalid = rvalid_q;
  assign bus.lk_rdata  = rdata_q;

  // Next state, arbitration and SRAM command selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_up_d = rr_up_q;
    init_d  = init_done;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    addr_d  = sram_addr0;
    din_d   = sram_din0;
    lk_gnt  = 1'b0;
    up_gnt  = 1'b0;
    unique case (state_q)
      SWEEP: begin
        csb_d  = 1'b0;
        web_d  = 1'b0;
        addr_d = cnt_q;
        din_d  = '0;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = RUN;
          init_d  = 1'b1;
        end
      end
      RUN: begin
        if (flush_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
          init_d  = 1'b0;
        end else begin
          up_gnt = bus.up_req &&
                   (!bus.lk_req || rr_up_q);
          lk_gnt = bus.lk_req && !up_gnt;
          if (bus.lk_req && bus.up_req)
            rr_up_d = !rr_up_q;
          if (up_gnt) begin
            csb_d  = 1'b0;
            web_d  = 1'b0;
            addr_d = bus.up_addr;
            din_d  = bus.up_wdata;
          end else if (lk_gnt) begin
            csb_d  = 1'b0;
            addr_d = bus.lk_addr;
          end
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  // FSM, arbiter pointer and SRAM command registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SWEEP;
      cnt_q      <= '0;
      rr_up_q    <= 1'b1;
      init_done  <= 1'b0;
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_up_q    <= rr_up_d;
      init_done  <= init_d;
      sram_csb0  <= csb_d;
      sram_web0  <= web_d;
      sram_addr0 <= addr_d;
      sram_din0  <= din_d;
    end
  end

  // Read tracking pipe and lookup data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q     <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rd_q     <= {rd_q[0], lk_gnt};
      rvalid_q <= rd_q[1];
      if (rd_q[1])
        rdata_q <= sram_dout0;
    end
  end

endmodule
